// File: rtl/systolic_out_deskew_if.sv
// rtl/systolic_out_deskew_if.sv - staggered lane input / aligned row output bus
interface systolic_out_deskew_if #(
  parameter int DATA_WIDTH = 18,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 8
);
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic [LANES-1:0]            in_valid;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic [CNT_WIDTH-1:0]        out_row_cnt;
  logic                        skew_err;

  modport master (
    output in_data, in_valid,
    input  out_data, out_valid, out_row_cnt, skew_err
  );

  modport slave (
    input  in_data, in_valid,
    output out_data, out_valid, out_row_cnt, skew_err
  );
endinterface

// File: rtl/systolic_out_deskew.sv
// rtl/systolic_out_deskew.sv - removes systolic output stagger; DESKEW_CHECK_EN adds misalignment check
// Lane k is delayed LANES-1-k cycles, then all lanes share one output register.
module systolic_out_deskew #(
  parameter int DATA_WIDTH = 18,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_out_deskew_if.slave  bus
);

  logic [DATA_WIDTH-1:0]       dly_data [LANES];
  logic [LANES-1:0]            dly_valid;
  logic [LANES*DATA_WIDTH-1:0] aligned;
  logic                        row_ok;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int DEPTH = LANES - 1 - k;
    if (DEPTH == 0) begin : g_pass
      assign dly_data[k]  = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
      assign dly_valid[k] = bus.in_valid[k];
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] d_q [DEPTH];
      logic [DEPTH-1:0]      v_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
          v_q[0] <= bus.in_valid[k];
          for (int i = 1; i < DEPTH; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign dly_data[k]  = d_q[DEPTH-1];
      assign dly_valid[k] = v_q[DEPTH-1];
    end
  end

  always_comb begin
    aligned = '0;
    for (int k = 0; k < LANES; k++) aligned[k*DATA_WIDTH +: DATA_WIDTH] = dly_data[k];
  end

`ifdef DESKEW_CHECK_EN
  assign row_ok = &dly_valid;
`else
  assign row_ok = dly_valid[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_data    <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_row_cnt <= '0;
    end else begin
      bus.out_data  <= aligned;
      bus.out_valid <= row_ok;
      if (row_ok) bus.out_row_cnt <= bus.out_row_cnt + 1'b1;
    end
  end

`ifdef DESKEW_CHECK_EN
  // A mix of set and clear valids means some lane slipped; the partial row is dropped above.
  always_ff @(posedge clk) begin
    if (reset) bus.skew_err <= 1'b0;
    else if ((|dly_valid) && !(&dly_valid)) bus.skew_err <= 1'b1;
  end
`else
  assign bus.skew_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_out_deskew.sv
// tb/tb_systolic_out_deskew.sv - scoreboard bench for systolic_out_deskew
module tb_systolic_out_deskew;
  localparam int DW = 18;
  localparam int LN = 4;
  localparam int CW = 8;

  typedef struct {
    logic [LN*DW-1:0] data;
    logic [CW-1:0]    cnt;
    int               due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_out_deskew_if #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) bus ();

  systolic_out_deskew #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t          sb[$];
  logic [DW-1:0] sched_d [LN+1][LN];
  logic          sched_v [LN+1][LN];
  int            edge_n = 0;
  int            n_cmp  = 0;
  int            n_bad  = 0;
  logic [CW-1:0] exp_cnt;
  bit            check_en;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_sched();
    for (int o = 0; o <= LN; o++)
      for (int k = 0; k < LN; k++) begin
        sched_d[o][k] = '0;
        sched_v[o][k] = 1'b0;
      end
  endtask

  task automatic sample();
    while (sb.size() > 0 && sb[0].due < edge_n) begin
      check_eq("row_missing", edge_n, sb[0].due);
      void'(sb.pop_front());
    end
    if (bus.out_valid) begin
      if (sb.size() == 0) check_eq("spurious_out_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("row_latency", edge_n, e.due);
        check_eq("row_data", bus.out_data, e.data);
        check_eq("row_cnt", bus.out_row_cnt, e.cnt);
      end
    end
  endtask

  task automatic cycle();
    for (int k = 0; k < LN; k++) begin
      bus.in_data[k*DW +: DW] = sched_d[0][k];
      bus.in_valid[k]         = sched_v[0][k];
    end
    @(posedge clk);
    edge_n++;
    for (int o = 0; o < LN; o++)
      for (int k = 0; k < LN; k++) begin
        sched_d[o][k] = sched_d[o+1][k];
        sched_v[o][k] = sched_v[o+1][k];
      end
    for (int k = 0; k < LN; k++) begin
      sched_d[LN][k] = '0;
      sched_v[LN][k] = 1'b0;
    end
    @(negedge clk);
    sample();
  endtask

  // Lane k of a row goes out k cycles after lane 0; late_lane slips one extra cycle.
  task automatic start_row(input logic [LN*DW-1:0] vals, input int late_lane,
                           input bit expect_row, input logic [LN*DW-1:0] exp_data);
    exp_t e;
    for (int k = 0; k < LN; k++) begin
      int o;
      o = (k == late_lane) ? k + 1 : k;
      sched_d[o][k] = vals[k*DW +: DW];
      sched_v[o][k] = 1'b1;
    end
    if (expect_row) begin
      exp_cnt = exp_cnt + 1'b1;
      e.data  = exp_data;
      e.cnt   = exp_cnt;
      e.due   = edge_n + LN;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    clear_sched();
    sb.delete();
    exp_cnt = '0;
    reset   = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data"}, bus.out_data, '0);
    check_eq({tag, "_valid"}, bus.out_valid, 0);
    check_eq({tag, "_cnt"}, bus.out_row_cnt, 0);
    check_eq({tag, "_skew"}, bus.skew_err, 0);
  endtask

  function automatic logic [LN*DW-1:0] make_row(input int base);
    logic [LN*DW-1:0] v;
    v = '0;
    for (int k = 0; k < LN; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  initial begin
    logic [LN*DW-1:0] v;
    logic [LN*DW-1:0] ev;
`ifdef DESKEW_CHECK_EN
    check_en = 1'b1;
`else
    check_en = 1'b0;
`endif
    reset        = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = '0;
    exp_cnt      = '0;
    clear_sched();

    do_reset(2);
    check_idle_outputs("reset");

    v = make_row(100);
    start_row(v, -1, 1'b1, v);
    repeat (LN + 3) cycle();
    check_eq("single_cnt", bus.out_row_cnt, 1);

    do_reset(1);
    for (int r = 0; r < 20; r++) begin
      v = make_row(r * 4);
      start_row(v, -1, 1'b1, v);
      cycle();
    end
    repeat (LN + 2) cycle();
    check_eq("stream_cnt", bus.out_row_cnt, 20);

    v = make_row(500);
    start_row(v, -1, 1'b0, v);
    cycle();
    cycle();
    do_reset(1);
    check_idle_outputs("midreset");
    repeat (LN + 2) cycle();
    check_eq("midreset_cnt_after", bus.out_row_cnt, 0);

    do_reset(1);
    for (int r = 0; r < 257; r++) begin
      v = make_row(r * 7);
      start_row(v, -1, 1'b1, v);
      cycle();
    end
    repeat (LN + 2) cycle();
    check_eq("wrap_cnt", bus.out_row_cnt, 1);

    do_reset(1);
    v  = make_row(1234);
    ev = v;
    ev[2*DW +: DW] = '0;
    start_row(v, 2, !check_en, ev);
    repeat (LN + 3) cycle();
    check_eq("misalign_skew", bus.skew_err, check_en);
    v = make_row(4321);
    start_row(v, -1, 1'b1, v);
    repeat (LN + 3) cycle();
    check_eq("misalign_skew_sticky", bus.skew_err, check_en);
    check_eq("misalign_cnt", bus.out_row_cnt, check_en ? 1 : 2);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/systolic_out_deskew.md
Name: systolic_out_deskew

Overview:
- Receive end of the systolic-array skew chain. Input-side delay lines stagger row data so lane k enters the array k cycles after lane 0. Results leave the array with the same stagger.
- This block removes that stagger. It delays lane k by LANES-1-k cycles, so each result row is presented as one aligned word with a single valid.
- It sits between the array's bottom edge and the result capture/correction logic.

Parameters:
- DATA_WIDTH, 18, bits per lane result.
- LANES, 4, number of lanes (columns). Minimum 2.
- CNT_WIDTH, 8, width of the output row counter.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- reset  input  1  synchronous reset, active-high.
- in_data  input  LANES*DATA_WIDTH  staggered lane data; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  LANES  per-lane valid; bit k qualifies lane k.
- out_data  output  LANES*DATA_WIDTH  aligned row, registered, same lane packing as in_data.
- out_valid  output  1  aligned row valid, registered, one-cycle pulse per row.
- out_row_cnt  output  CNT_WIDTH  count of rows emitted since reset, registered.
- skew_err  output  1  sticky misalignment flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (synchronous, while reset=1 at a rising edge):
  - All delay-chain data and valid registers clear to 0.
  - out_data=0, out_valid=0, out_row_cnt=0, skew_err=0.
  - Reset mid-row discards all partially aligned rows. Nothing from before reset may appear at the output afterwards.
- Delay chain:
  - Lane k passes through LANES-1-k data/valid stages, then one common output register.
  - Lane LANES-1 has no chain stage, only the output register.
- Latency:
  - A row whose lane 0 is sampled at edge E (lane k sampled at E+k) is captured at edge E+LANES-1.
  - It is visible on out_data/out_valid for the cycle after that edge.
  - This is 1 cycle after the last lane; LANES cycles measured from lane 0.
- No backpressure. The block accepts one row per cycle. Back-to-back rows (lane 0 valid on consecutive cycles) produce out_valid high on consecutive cycles.
- out_data is updated every edge, valid or not. Consumers qualify it with out_valid.
- out_valid at the capture edge = AND of all delayed lane valids. Without the optional feature it is the delayed lane 0 valid only.
- out_row_cnt:
  - Increments by 1 at each edge where out_valid is set.
  - Wraps from 2^CNT_WIDTH-1 to 0 silently.
  - Holds otherwise.
  - It is updated in the same edge as out_valid, so during the first valid row it reads 1.
- Reset and valid data at the same edge: reset wins.

Optional Feature:
Macro DESKEW_CHECK_EN.
- Defined:
  - At each capture edge, compare the LANES delayed valid bits.
  - All 1: normal row.
  - All 0: idle.
  - Mixed: misalignment. skew_err sets to 1 and stays set until reset. out_valid=0 for that slot and out_row_cnt does not increment; the partial row is dropped.
- Not defined:
  - No comparison is made. out_valid follows the delayed lane 0 valid, and lanes 1..LANES-1 valids are ignored.
  - skew_err is driven constant 0.

Test Plan (DATA_WIDTH=18, LANES=4, CNT_WIDTH=8):
- Single row: lane k gets value 100+k with its valid at cycle t+k, idle otherwise -> one out_valid pulse after edge t+3, out_data lanes = {103,102,101,100} (lane 3 high), out_row_cnt=1.
- Streaming: 20 consecutive rows, row r lane k = r*4+k, correctly staggered -> 20 consecutive out_valid cycles, each row aligned, out_row_cnt ends at 20.
- Reset mid-stream: assert reset for one edge after lane 0 and lane 1 of a row were accepted -> no out_valid for that row, all outputs 0 the cycle after reset, out_row_cnt=0.
- Counter wrap: emit 257 rows -> out_row_cnt reads 255, then 0, then 1.
- Misalignment (DESKEW_CHECK_EN defined): drive lane 2 valid one cycle late for one row (1234 on lane 0) -> that slot has no out_valid, skew_err=1 and stays 1; the following good row (4321) still emits, out_row_cnt increments.
- Same misaligned stimulus without the macro -> out_valid pulses for the row and skew_err stays 0.
